sched_sequencer: RTL and testbench

SCHED_SEQUENCER -- requirements
Module: sched_sequencer

---
 rtl/sched_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_sched_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sched_sequencer.sv
// sched_sequencer
//   Loads a schedule of CTRL_DEPTH control words into a buffer controller,
//   then runs it for a number of iterations, one control word period each.
//
//   Ports
//     clk, rst            clock (rising edge), synchronous active-high reset
//     cfg_valid/ready     schedule word handshake; cfg_word data, cfg_last marks final word
//     run_req, num_iter   start a run of num_iter iterations (0 = until abort)
//     abort               stop at the next iteration boundary
//     ctrl_in, load_ctrl  word and write strobe to the buffer controller
//     start_ctrl          one-cycle pulse on the first cycle of a run
//     stop_ctrl           one-cycle pulse on the last cycle of a run
//     busy                loading or running
//     done                one-cycle pulse on natural completion
//     aborted, err        sticky: last run ended by abort / last load had wrong length
//     iter_cnt            completed iterations in the current run
//
//   CTRL_DEPTH must be at least 2 so start_ctrl and stop_ctrl land in
//   different cycles.
module sched_sequencer #(
   parameter int CTRL_WIDTH = 24,
   parameter int CTRL_DEPTH = 48,
   parameter int ITER_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CTRL_WIDTH-1:0] cfg_word,
   input  logic                  cfg_last,
   input  logic                  run_req,
   input  logic [ITER_W-1:0]     num_iter,
   input  logic                  abort,
   output logic [CTRL_WIDTH-1:0] ctrl_in,
   output logic                  load_ctrl,
   output logic                  start_ctrl,
   output logic                  stop_ctrl,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  err,
   output logic [ITER_W-1:0]     iter_cnt
);

   // One extra count value lets the pad counter run one past the last word,
   // which keeps cfg_ready low through the final pad strobe.
   localparam int CNT_W = $clog2(CTRL_DEPTH + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CTRL_DEPTH - 1);
   localparam logic [CNT_W-1:0] PAD_END  = CNT_W'(CTRL_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED, S_RUN} state_t;

   state_t                state_reg;
   logic [CNT_W-1:0]      wcnt_reg;
   logic [CNT_W-1:0]      phase_reg;
   logic [ITER_W-1:0]     iter_reg;
   logic [ITER_W-1:0]     num_reg;
   logic                  pad_reg;
   logic                  pend_reg;
   logic [CTRL_WIDTH-1:0] ctrl_reg;
   logic                  load_reg;
   logic                  start_reg;
   logic                  stop_reg;
   logic                  done_reg;
   logic                  aborted_reg;
   logic                  err_reg;

   logic                  xfer;
   logic [CNT_W-1:0]      word_idx;
   logic [CNT_W-1:0]      phase_next;
   logic [ITER_W-1:0]     iter_inc;
   logic [ITER_W-1:0]     iter_next;
   logic                  pend_next;
   logic                  finish_next;

   assign cfg_ready  = (state_reg != S_RUN) && !pad_reg;
   assign busy       = (state_reg == S_LOAD) || (state_reg == S_RUN);
   assign ctrl_in    = ctrl_reg;
   assign load_ctrl  = load_reg;
   assign start_ctrl = start_reg;
   assign stop_ctrl  = stop_reg;
   assign done       = done_reg;
   assign aborted    = aborted_reg;
   assign err        = err_reg;
   assign iter_cnt   = iter_reg;

   // Look-ahead terms: stop_ctrl/done are registered, so they are decided one
   // edge early from what phase, iteration and pending flag will be next.
   always_comb begin
      xfer        = cfg_valid & cfg_ready;
      word_idx    = (state_reg == S_LOAD) ? wcnt_reg : '0;
      phase_next  = (phase_reg == LAST_IDX) ? '0 : phase_reg + CNT_W'(1);
      iter_inc    = (&iter_reg) ? iter_reg : iter_reg + ITER_W'(1);
      iter_next   = (phase_reg == LAST_IDX) ? iter_inc : iter_reg;
      pend_next   = pend_reg | abort;
      finish_next = (num_reg != '0) && (iter_next == num_reg - ITER_W'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         wcnt_reg    <= '0;
         phase_reg   <= '0;
         iter_reg    <= '0;
         num_reg     <= '0;
         pad_reg     <= 1'b0;
         pend_reg    <= 1'b0;
         ctrl_reg    <= '0;
         load_reg    <= 1'b0;
         start_reg   <= 1'b0;
         stop_reg    <= 1'b0;
         done_reg    <= 1'b0;
         aborted_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         load_reg  <= 1'b0;
         start_reg <= 1'b0;
         stop_reg  <= 1'b0;
         done_reg  <= 1'b0;

         if (state_reg == S_RUN) begin
            if (stop_reg) begin
               // Last cycle of the run: the wrap still counts as a completed
               // iteration, and done_reg tells completion from abort.
               state_reg <= S_LOADED;
               phase_reg <= '0;
               iter_reg  <= iter_inc;
               pend_reg  <= 1'b0;
               if (!done_reg)
                  aborted_reg <= 1'b1;
            end else begin
               phase_reg <= phase_next;
               iter_reg  <= iter_next;
               pend_reg  <= pend_next;
               stop_reg  <= (phase_next == LAST_IDX) && (finish_next || pend_next);
               done_reg  <= (phase_next == LAST_IDX) && finish_next;
            end
         end else if (pad_reg) begin
            // Filling out a short schedule with zero words.
            if (wcnt_reg == PAD_END) begin
               pad_reg   <= 1'b0;
               wcnt_reg  <= '0;
               state_reg <= S_IDLE;
            end else begin
               load_reg <= 1'b1;
               ctrl_reg <= '0;
               wcnt_reg <= wcnt_reg + CNT_W'(1);
            end
         end else if (xfer) begin
            // A transfer wins over run_req; from IDLE/LOADED it is word 0.
            load_reg <= 1'b1;
            ctrl_reg <= cfg_word;
            if (cfg_last && word_idx == LAST_IDX) begin
               state_reg <= S_LOADED;
               wcnt_reg  <= '0;
               err_reg   <= 1'b0;
            end else if (cfg_last) begin
               state_reg <= S_LOAD;
               err_reg   <= 1'b1;
               pad_reg   <= 1'b1;
               wcnt_reg  <= word_idx + CNT_W'(1);
            end else if (word_idx == LAST_IDX) begin
               state_reg <= S_IDLE;
               wcnt_reg  <= '0;
               err_reg   <= 1'b1;
            end else begin
               state_reg <= S_LOAD;
               wcnt_reg  <= word_idx + CNT_W'(1);
            end
         end else if (state_reg == S_LOADED && run_req) begin
            state_reg   <= S_RUN;
            start_reg   <= 1'b1;
            num_reg     <= num_iter;
            phase_reg   <= '0;
            iter_reg    <= '0;
            pend_reg    <= 1'b0;
            aborted_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sched_sequencer.sv
// tb_sched_sequencer
//   Randomized bench for sched_sequencer at CTRL_DEPTH=4. Each load or run
//   computes its expected strobes (cycle and data) from the schedule rules
//   and queues them; a negedge monitor pops one entry per strobe seen.
module tb_sched_sequencer;

   localparam int D    = 4;
   localparam int CW   = 8;
   localparam int IW   = 4;
   localparam int MAXI = (1 << IW) - 1;

   localparam int EV_LOAD  = 0;
   localparam int EV_START = 1;
   localparam int EV_STOP  = 2;
   localparam int EV_DONE  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_word;
   logic          cfg_last;
   logic          run_req;
   logic [IW-1:0] num_iter;
   logic          abort;
   logic [CW-1:0] ctrl_in;
   logic          load_ctrl;
   logic          start_ctrl;
   logic          stop_ctrl;
   logic          busy;
   logic          done;
   logic          aborted;
   logic          err;
   logic [IW-1:0] iter_cnt;

   sched_sequencer #(.CTRL_WIDTH(CW), .CTRL_DEPTH(D), .ITER_W(IW)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_word(cfg_word), .cfg_last(cfg_last),
      .run_req(run_req), .num_iter(num_iter), .abort(abort),
      .ctrl_in(ctrl_in), .load_ctrl(load_ctrl), .start_ctrl(start_ctrl), .stop_ctrl(stop_ctrl),
      .busy(busy), .done(done), .aborted(aborted), .err(err), .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          kind;
      int          cyc;
      logic [CW-1:0] data;
   } ev_t;
   ev_t exp_q[$];

   function automatic string kname(input int k);
      if (k == EV_LOAD)  return "load";
      if (k == EV_START) return "start";
      if (k == EV_STOP)  return "stop";
      return "done";
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic push_ev(input int k, input int c, input logic [CW-1:0] d);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic see_ev(input int k, input logic [CW-1:0] d);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s: got strobe at cycle %0d, expected none", kname(k), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc || (k == EV_LOAD && e.data != d)) begin
            failures++;
            $display("FAIL event: got %s cycle %0d data %0h, expected %s cycle %0d data %0h",
                     kname(k), cyc, d, kname(e.kind), e.cyc, e.data);
         end
      end
   endtask

   // Monitor: every strobe the DUT presents must match the next queued one.
   always @(negedge clk) begin
      if (load_ctrl)  see_ev(EV_LOAD, ctrl_in);
      if (start_ctrl) see_ev(EV_START, '0);
      if (stop_ctrl)  see_ev(EV_STOP, '0);
      if (done)       see_ev(EV_DONE, '0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_cfg_ready"}, int'(cfg_ready), 1);
      check({tag, "_ctrl_in"},   int'(ctrl_in), 0);
      check({tag, "_load"},      int'(load_ctrl), 0);
      check({tag, "_start"},     int'(start_ctrl), 0);
      check({tag, "_stop"},      int'(stop_ctrl), 0);
      check({tag, "_busy"},      int'(busy), 0);
      check({tag, "_done"},      int'(done), 0);
      check({tag, "_aborted"},   int'(aborted), 0);
      check({tag, "_err"},       int'(err), 0);
      check({tag, "_iter"},      int'(iter_cnt), 0);
   endtask

   // run_req outside LOADED must produce nothing (the monitor flags any start).
   task automatic idle_run_req();
      run_req  = 1'b1;
      num_iter = IW'(1);
      step();
      run_req = 1'b0;
      step();
      check("idle_run_busy", int'(busy), 0);
   endtask

   // Loads nwords words; last_idx is the word carrying cfg_last (-1: none).
   // collide raises run_req alongside the first word. ok = schedule valid.
   task automatic load_op(input int nwords, input int last_idx, input bit collide, output bit ok);
      int            e;
      int            p;
      logic [CW-1:0] w;
      e = 0;
      for (int i = 0; i < nwords; i++) begin
         repeat ($urandom_range(0, 2)) step();
         w         = CW'($urandom);
         cfg_valid = 1'b1;
         cfg_word  = w;
         cfg_last  = (i == last_idx);
         run_req   = collide && (i == 0);
         num_iter  = IW'(1);
         check("ready_for_word", int'(cfg_ready), 1);
         step();
         e         = cyc;
         cfg_valid = 1'b0;
         cfg_last  = 1'b0;
         run_req   = 1'b0;
         push_ev(EV_LOAD, e, w);
         if (collide && i == 0 && nwords > 1) check("collide_busy", int'(busy), 1);
      end
      if (last_idx == D - 1) begin
         check("full_err", int'(err), 0);
         check("full_busy", int'(busy), 0);
         ok = 1'b1;
      end else if (last_idx >= 0) begin
         p = D - 1 - last_idx;
         for (int k = 1; k <= p; k++) push_ev(EV_LOAD, e + k, '0);
         for (int k = 0; k <= p; k++) begin
            check("pad_ready_low", int'(cfg_ready), 0);
            step();
         end
         check("early_busy", int'(busy), 0);
         check("early_err", int'(err), 1);
         check("early_ready", int'(cfg_ready), 1);
         ok = 1'b0;
      end else begin
         check("missing_err", int'(err), 1);
         check("missing_busy", int'(busy), 0);
         ok = 1'b0;
      end
   endtask

   // One run of n iterations; if use_abort, abort is raised for one cycle
   // at offset j from the start_ctrl cycle.
   task automatic run_op(input int n, input bit use_abort, input int j);
      int t, nat, end_c, a, ca, exp_iter;
      bit is_done;
      run_req  = 1'b1;
      num_iter = IW'(n);
      step();
      run_req  = 1'b0;
      num_iter = IW'($urandom);   // must already be latched
      t        = cyc;
      nat      = (n > 0) ? t + n * D - 1 : t + 100000;
      end_c    = nat;
      is_done  = (n > 0);
      a        = t + j;
      if (use_abort && a < nat) begin
         ca = t + (j / D) * D + D - 1;
         if (ca <= a) ca += D;
         if (ca < nat) begin
            end_c   = ca;
            is_done = 1'b0;
         end
      end
      exp_iter = is_done ? n : imin((end_c - t + 1) / D, MAXI);
      push_ev(EV_START, t, '0);
      push_ev(EV_STOP, end_c, '0);
      if (is_done) push_ev(EV_DONE, end_c, '0);

      abort = use_abort && (a == t);
      for (int guard = 0; cyc <= end_c && guard < 2000; guard++) begin
         if (cyc == end_c) begin
            check("iter_at_stop", int'(iter_cnt), imin((end_c - t) / D, MAXI));
            check("busy_at_stop", int'(busy), 1);
         end
         step();
         abort = use_abort && (cyc == a) && (cyc <= end_c);
      end
      abort = 1'b0;
      check("run_ended_in_time", cyc, end_c + 1);
      check("post_run_busy", int'(busy), 0);
      check("post_run_aborted", int'(aborted), is_done ? 0 : 1);
      check("post_run_iter", int'(iter_cnt), exp_iter);
      $display("run n=%0d abort=%0d j=%0d start=%0d stop=%0d done=%0d iter=%0d",
               n, use_abort, j, t, end_c, is_done, exp_iter);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit loaded;
      bit ok;
      int t;
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_word  = '0;
      cfg_last  = 1'b0;
      run_req   = 1'b0;
      num_iter  = '0;
      abort     = 1'b0;
      repeat (3) step();
      check_cleared("reset");
      rst = 1'b0;
      step();
      idle_run_req();

      // Directed: full load, completion, abort, coincidence, saturation.
      load_op(D, D - 1, 1'b0, loaded);
      $display("load full ok=%0d", loaded);
      run_op(2, 1'b0, 0);
      run_op(0, 1'b1, 3 * D + 1);
      run_op(2, 1'b1, 2 * D - 2);
      run_op(1, 1'b1, D - 1);
      run_op(0, 1'b1, 17 * D + 1);

      // Directed: early load, missing last, collision.
      load_op(2, 1, 1'b0, loaded);
      $display("load early ok=%0d", loaded);
      idle_run_req();
      load_op(D, -1, 1'b0, loaded);
      $display("load missing-last ok=%0d", loaded);
      load_op(D, D - 1, 1'b0, loaded);
      load_op(D, D - 1, 1'b1, loaded);
      $display("load collide ok=%0d", loaded);
      run_op(1, 1'b0, 0);

      // Directed: reset at phase 2 of a run.
      run_req  = 1'b1;
      num_iter = '0;
      step();
      run_req = 1'b0;
      t       = cyc;
      push_ev(EV_START, t, '0);
      step();
      step();
      rst = 1'b1;
      step();
      check_cleared("midrun_reset");
      rst = 1'b0;
      $display("reset mid-run start=%0d", t);
      idle_run_req();
      loaded = 1'b0;

      // Random mix of loads and runs.
      for (int r = 0; r < 25; r++) begin
         int kind;
         bit coll;
         kind = $urandom_range(0, 9);
         coll = loaded && ($urandom_range(0, 3) == 0);
         if (kind < 6)      load_op(D, D - 1, coll, ok);
         else if (kind < 8) load_op(D, -1, coll, ok);
         else begin
            int li;
            li = $urandom_range(0, D - 2);
            load_op(li + 1, li, coll, ok);
         end
         loaded = ok;
         $display("load round=%0d kind=%0d collide=%0d ok=%0d", r, kind, coll, ok);
         if (loaded) begin
            repeat ($urandom_range(1, 3)) begin
               int n;
               n = $urandom_range(0, 3);
               if (n == 0) run_op(0, 1'b1, $urandom_range(0, 3 * D));
               else        run_op(n, 1'($urandom_range(0, 1)), $urandom_range(0, n * D - 1));
            end
         end else begin
            idle_run_req();
         end
      end

      repeat (4) step();
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
